mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: maximum consecutive cycles a requesting CPU may be denied.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled only on posedge clk.
REQ-004 SHALL have port cpu_req, input, 1 bit: CPU requests an access this cycle (memread or memwrite from the control FSM).
REQ-005 SHALL have port cpu_we, input, 1 bit: CPU access is a write when 1, a read when 0.
REQ-006 SHALL have port cpu_addr, input, 16 bits: CPU address.
REQ-007 SHALL have port cpu_wdata, input, 16 bits: CPU write data.
REQ-008 SHALL have port cpu_gnt, output, 1 bit: CPU access is issued to memory this cycle.
REQ-009 SHALL have port cpu_rdata, output, 16 bits: CPU read data.
REQ-010 SHALL have port cpu_rvalid, output, 1 bit: cpu_rdata is valid this cycle.
REQ-011 SHALL have port vga_req, input, 1 bit: display reader requests a read.
REQ-012 SHALL have port vga_addr, input, 16 bits: display read address.
REQ-013 SHALL have port vga_gnt, output, 1 bit: display read is issued to memory this cycle.
REQ-014 SHALL have port vga_rdata, output, 16 bits: display read data.
REQ-015 SHALL have port vga_rvalid, output, 1 bit: vga_rdata is valid this cycle.
REQ-016 SHALL have port mem_en, output, 1 bit: memory access enable.
REQ-017 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-018 SHALL have port mem_addr, output, 16 bits: memory address.
REQ-019 SHALL have port mem_wdata, output, 16 bits: memory write data.
REQ-020 SHALL have port mem_rdata, input, 16 bits: memory read data, valid one cycle after a read is issued.

Function
REQ-021 SHALL issue at most one access per cycle; cpu_gnt and vga_gnt SHALL be combinational and mutually exclusive.
REQ-022 SHALL arbitrate by priority: vga wins when both request, unless wait_cnt == MAX_WAIT, in which case cpu wins.
REQ-023 SHALL grant a lone requester in the same cycle; no request -> no grant, mem_en=0.
REQ-024 SHALL hold wait_cnt as a counter: +1 on a cycle with cpu_req=1 and cpu_gnt=0, cleared on cpu_gnt or cpu_req=0, saturating at MAX_WAIT.
REQ-025 SHALL drive the memory port from the winner: mem_en=1, mem_addr/mem_wdata from the winner, mem_we=cpu_we only when cpu wins (vga never writes); when idle, mem_we=0 and mem_addr/mem_wdata=0.
REQ-026 SHALL implement a read-return FSM with states IDLE, RD_CPU, RD_VGA; next state = RD_CPU on a granted CPU read, RD_VGA on a granted vga read, else IDLE.
REQ-027 SHALL assert cpu_rvalid in RD_CPU and vga_rvalid in RD_VGA (exactly 1 cycle after grant); both rdata outputs SHALL equal mem_rdata, and each is valid only with its own rvalid.
REQ-028 SHALL produce no rvalid for a CPU write; its state SHALL go to IDLE.
REQ-029 SHALL allow back-to-back grants: a grant in the cycle its predecessor's rvalid is asserted is legal, and the two are tracked independently.
REQ-030 SHALL allow a requester to hold req high across cycles; each granted cycle is a separate access.
REQ-031 SHALL force the CPU grant whenever wait_cnt == MAX_WAIT and cpu_req=1, regardless of vga_req.

Reset
REQ-032 SHALL, when reset=0 at posedge clk, set state=IDLE and wait_cnt=0, and SHALL force cpu_rvalid=vga_rvalid=0 the following cycle; a read granted in the reset cycle SHALL be dropped (no rvalid).
REQ-033 SHALL gate all grants and mem_en to 0 while reset=0.

Verification
REQ-034 SHALL verify: CPU read alone, addr 0x0010, mem returns 0xBEEF -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0xBEEF next cycle.
REQ-035 SHALL verify: CPU write alone, addr 0x0020, data 0x1234 -> mem_en=1, mem_we=1, mem_addr=0x0020, mem_wdata=0x1234, no rvalid next cycle.
REQ-036 SHALL verify: both requesters held high continuously, MAX_WAIT=4 -> vga granted 4 cycles, cpu on the 5th, wait_cnt back to 0, pattern repeats.
REQ-037 SHALL verify: alternating grants cpu, vga, cpu on consecutive cycles -> rvalids route one cycle later in the same order, with no crossover.
REQ-038 SHALL verify: reset=0 asserted in the cycle of a vga grant -> no vga_rvalid next cycle, wait_cnt=0, state=IDLE.
REQ-039 SHALL verify: no requests -> mem_en=0, mem_we=0, both gnt=0, both rvalid=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the CPU and the display reader.
// The display has priority, but a CPU starved for MAX_WAIT cycles is forced through.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        vga_req,
    input  logic [15:0] vga_addr,
    output logic        vga_gnt,
    output logic [15:0] vga_rdata,
    output logic        vga_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_CPU,
        RD_VGA
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            cpu_force;

    always_comb begin
        cpu_force = cpu_req && (wait_cnt_q == CW'(MAX_WAIT));
        cpu_gnt   = reset && cpu_req && (!vga_req || cpu_force);
        vga_gnt   = reset && vga_req && !cpu_gnt;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (vga_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = vga_addr;
        end
    end

    // Starvation counter: counts only consecutive denied CPU requests.
    always_comb begin
        wait_cnt_d = '0;
        if (cpu_req && !cpu_gnt) begin
            if (wait_cnt_q == CW'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        if (cpu_gnt && !cpu_we) begin
            state_d = RD_CPU;
        end else if (vga_gnt) begin
            state_d = RD_VGA;
        end
    end

    // Memory returns data one cycle after issue; the state remembers who asked.
    assign cpu_rvalid = (state_q == RD_CPU);
    assign vga_rvalid = (state_q == RD_VGA);
    assign cpu_rdata  = mem_rdata;
    assign vga_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle reference model plus
// hand-computed literal expectations for the key scenarios.
module tb_mem_port_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        vga_req = 1'b0;
    logic [15:0] vga_addr = '0;
    logic        cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid;
    logic [15:0] cpu_rdata, vga_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [15:0] ram       [0:255];
    logic [15:0] model_ram [0:255];

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_gnt(vga_gnt), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 16'h1000 + 16'(i);
            model_ram[i] = 16'h1000 + 16'(i);
        end
        ram[8'h10]       = 16'hBEEF;
        model_ram[8'h10] = 16'hBEEF;
    end

    // Synchronous single-port RAM behind the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: wait count, pending read return and the data it must carry.
    int          m_wait = 0;
    logic        p_cpu = 1'b0, p_vga = 1'b0;
    logic [15:0] p_data = '0;

    initial begin
        logic        e_c, e_v;
        logic [15:0] e_addr;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_c    = reset && cpu_req && (!vga_req || m_wait == MAX_WAIT);
            e_v    = reset && vga_req && !e_c;
            e_addr = e_c ? cpu_addr : (e_v ? vga_addr : 16'h0000);
            chk("cpu_gnt", 32'(cpu_gnt), 32'(e_c));
            chk("vga_gnt", 32'(vga_gnt), 32'(e_v));
            chk("mem_en", 32'(mem_en), 32'(e_c | e_v));
            chk("mem_we", 32'(mem_we), 32'(e_c & cpu_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_c ? cpu_wdata : 16'h0000));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(p_cpu));
            chk("vga_rvalid", 32'(vga_rvalid), 32'(p_vga));
            if (p_cpu) chk("cpu_rdata", 32'(cpu_rdata), 32'(p_data));
            if (p_vga) chk("vga_rdata", 32'(vga_rdata), 32'(p_data));

            if (!reset) begin
                m_wait = 0;
                p_cpu  = 1'b0;
                p_vga  = 1'b0;
            end else begin
                p_cpu  = e_c && !cpu_we;
                p_vga  = e_v;
                p_data = model_ram[e_addr[7:0]];
                if (e_c && cpu_we) model_ram[cpu_addr[7:0]] = cpu_wdata;
                if (cpu_req && !e_c) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
                else                 m_wait = 0;
            end
        end
    end

    task automatic step(input logic rst, input logic creq, input logic cwe,
                        input logic [15:0] caddr, input logic [15:0] cwd,
                        input logic vreq, input logic [15:0] vaddr);
        @(posedge clk);
        #1;
        reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr;
        cpu_wdata = cwd; vga_req = vreq; vga_addr = vaddr;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    logic [9:0] vga_pat;

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rvalid", 32'({cpu_rvalid, vga_rvalid}), 32'd0);

        // No requests
        idle();
        chk("idle_gnt", 32'({cpu_gnt, vga_gnt}), 32'd0);
        chk("idle_mem", 32'({mem_en, mem_we}), 32'd0);
        chk("idle_rvalid", 32'({cpu_rvalid, vga_rvalid}), 32'd0);

        // CPU read alone
        step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        chk("rd_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_addr", 32'(mem_addr), 32'h0010);
        idle();
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_data", 32'(cpu_rdata), 32'hBEEF);

        // CPU write alone
        step(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0);
        chk("wr_port", 32'({mem_en, mem_we}), 32'h3);
        chk("wr_addr", 32'(mem_addr), 32'h0020);
        chk("wr_wdata", 32'(mem_wdata), 32'h1234);
        idle();
        chk("wr_no_rvalid", 32'({cpu_rvalid, vga_rvalid}), 32'd0);

        // Both held high: vga 4 cycles, cpu on the 5th, repeating
        vga_pat = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0030);
            chk("starve_vga", 32'(vga_gnt), 32'(vga_pat[i]));
            chk("starve_cpu", 32'(cpu_gnt), 32'(!vga_pat[i]));
        end
        idle();

        // Alternating cpu, vga, cpu: returns in the same order
        step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0030);
        chk("alt1_cpu_rv", 32'({cpu_rvalid, vga_rvalid}), 32'h2);
        chk("alt1_data", 32'(cpu_rdata), 32'hBEEF);
        step(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0);
        chk("alt2_vga_rv", 32'({cpu_rvalid, vga_rvalid}), 32'h1);
        chk("alt2_data", 32'(vga_rdata), 32'h1030);
        idle();
        chk("alt3_cpu_rv", 32'({cpu_rvalid, vga_rvalid}), 32'h2);
        chk("alt3_data", 32'(cpu_rdata), 32'h1234);
        idle();

        // Reset during a vga request drops it and clears the starvation count
        step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0050);
        step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0050);
        step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0050);
        chk("rstg_gnt", 32'({cpu_gnt, vga_gnt, mem_en}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0050);
            if (i == 0) chk("rstg_no_rvalid", 32'(vga_rvalid), 32'd0);
            chk("rstg_vga", 32'(vga_gnt), 32'(i < 4));
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
